axi4_switch_custom: RTL and testbench
=====================================

AXI4_SWITCH_CUSTOM -- requirements
Module: axi4_switch_custom

Interface
REQ-001 SHALL have parameter TDATA_L, default 512, meaning tdata width in bits.
REQ-002 SHALL have parameter TUSER_L, default 81, meaning tuser width in bits.
REQ-003 SHALL have parameter TKEEP_L, default 16, meaning tkeep width in bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port s_req_supress, input, 2, where bit i masks new-packet requests from slave i.
REQ-007 SHALL have ports axi_sN_tdata_i, axi_sN_tuser_i, axi_sN_tkeep_i, axi_sN_tlast_i and axi_sN_tvalid_i (N=0,1), inputs, widths TDATA_L, TUSER_L, TKEEP_L, 1 and 1, forming the slave stream N.
REQ-008 SHALL have port axi_sN_tready_o (N=0,1), output, 1, ready for slave N.
REQ-009 SHALL have ports axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tkeep_o, axi_m0_tlast_o and axi_m0_tvalid_o, outputs, widths TDATA_L, TUSER_L, TKEEP_L, 1 and 1, forming the master stream.
REQ-010 SHALL have port axi_m0_tready_i, input, 1, master ready.

Function
REQ-011 SHALL merge two AXI4-Stream slaves into one master at packet granularity; beats of one packet are never interleaved with the other port.
REQ-012 SHALL transfer a beat only on the same-edge handshake tvalid&tready; a packet ends on the beat accepted with tlast=1.
REQ-013 SHALL implement arbiter states IDLE, GNT0 and GNT1.
REQ-014 SHALL treat req_i as axi_si_tvalid_i & ~s_req_supress[i] when in IDLE.
REQ-015 SHALL, in IDLE with exactly one request, move to the GNT state of that requester on the next edge.
REQ-016 SHALL, in IDLE with both requests, grant the port not served last; after reset, port 0 wins the first tie.
REQ-017 SHALL, in GNTi, hold the grant until the tlast beat of slave i is accepted, then return to IDLE, which costs one bubble cycle between packets.
REQ-018 SHALL NOT let s_req_supress abort a packet already granted.
REQ-019 SHALL drive axi_si_tready_o = (state==GNTi) & (~out_valid | axi_m0_tready_i); the ungranted port's tready is 0.
REQ-020 SHALL register the output as a single slice: an accepted input beat loads tdata, tuser, tkeep and tlast into the output register and sets out_valid, giving 1-cycle latency from input handshake to axi_m0_tvalid_o.
REQ-021 SHALL clear out_valid on an output handshake when no new beat loads in the same cycle; a simultaneous load and unload keeps out_valid=1, for full throughput of 1 beat/cycle.
REQ-022 SHALL hold master output data stable while axi_m0_tvalid_o=1 and axi_m0_tready_i=0.
REQ-023 SHALL pass tdata, tuser, tkeep and tlast unmodified and in order per port.

Reset
REQ-024 SHALL, while rst=1, set state=IDLE, out_valid=0, last-served pointer=port 1 (so port 0 wins the first tie), and both tready outputs to 0.
REQ-025 SHALL, on a reset mid-packet, drop the partial packet and lose the output register contents; the output data registers need no reset.
REQ-026 SHALL drive axi_m0_tvalid_o=0 in the first cycle after reset release.

Configuration
REQ-027 SHALL, with macro AXI4_SWITCH_REQ_SUPRESS_EN defined, apply s_req_supress per REQ-014.
REQ-028 SHALL, without AXI4_SWITCH_REQ_SUPRESS_EN, keep the s_req_supress port but ignore it, so req_i = axi_si_tvalid_i.

Verification
REQ-029 SHALL check a single-beat packet: s0 data 0xA0A00000, tlast=1, m0 ready=1 -> the same data, user and last appear on m0 one cycle after acceptance, exactly once.
REQ-030 SHALL check no interleaving: s1 sends a 3-beat packet 0xB0B00001..03 while s0 offers 0xA0A00004 -> m0 carries all three s1 beats contiguously, then the s0 beat.
REQ-031 SHALL check tie fairness: both ports offer 2-beat packets in the same cycle with repeated back-to-back packets -> grants alternate 0,1,0,1 starting with port 0 after reset, and per-port order is preserved.
REQ-032 SHALL check back-pressure: axi_m0_tready_i=0 for 5 cycles mid-packet -> m0 output is held stable, slave tready falls, and no beat is lost or duplicated.
REQ-033 SHALL check suppression: s_req_supress=2'b01 with both ports valid in IDLE -> port 1 is granted and port 0 waits; clearing the mask lets port 0 be granted next.
REQ-034 SHALL check reset mid-packet: assert rst after the first of 2 beats -> axi_m0_tvalid_o=0, state IDLE, and the next packet is delivered intact.

Source files
------------

// File: rtl/axi4_switch_custom.sv
// Two-slave to one-master AXI4-Stream packet switch with a single output register slice.
// Build option: define AXI4_SWITCH_REQ_SUPRESS_EN to let s_req_supress mask new-packet requests.
module axi4_switch_custom #(
  parameter int TDATA_L = 512,
  parameter int TUSER_L = 81,
  parameter int TKEEP_L = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         s_req_supress,
  input  logic [TDATA_L-1:0] axi_s0_tdata_i,
  input  logic [TUSER_L-1:0] axi_s0_tuser_i,
  input  logic [TKEEP_L-1:0] axi_s0_tkeep_i,
  input  logic               axi_s0_tlast_i,
  input  logic               axi_s0_tvalid_i,
  output logic               axi_s0_tready_o,
  input  logic [TDATA_L-1:0] axi_s1_tdata_i,
  input  logic [TUSER_L-1:0] axi_s1_tuser_i,
  input  logic [TKEEP_L-1:0] axi_s1_tkeep_i,
  input  logic               axi_s1_tlast_i,
  input  logic               axi_s1_tvalid_i,
  output logic               axi_s1_tready_o,
  output logic [TDATA_L-1:0] axi_m0_tdata_o,
  output logic [TUSER_L-1:0] axi_m0_tuser_o,
  output logic [TKEEP_L-1:0] axi_m0_tkeep_o,
  output logic               axi_m0_tlast_o,
  output logic               axi_m0_tvalid_o,
  input  logic               axi_m0_tready_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t               state_reg;
  logic                 last_reg;       // 1 when port 1 was the most recent grant
  logic                 out_valid_reg;
  logic [TDATA_L-1:0]   out_tdata_reg;
  logic [TUSER_L-1:0]   out_tuser_reg;
  logic [TKEEP_L-1:0]   out_tkeep_reg;
  logic                 out_tlast_reg;

  logic [TDATA_L-1:0]   s_tdata [2];
  logic [TUSER_L-1:0]   s_tuser [2];
  logic [TKEEP_L-1:0]   s_tkeep [2];
  logic [1:0]           s_tlast;
  logic [1:0]           s_tvalid;
  logic [1:0]           s_tready;
  logic [1:0]           s_take;
  logic [1:0]           req;
  logic [1:0]           grant;
  logic                 out_ready;
  logic                 take_any;
  logic                 sel_port;

  assign s_tdata[0] = axi_s0_tdata_i;
  assign s_tdata[1] = axi_s1_tdata_i;
  assign s_tuser[0] = axi_s0_tuser_i;
  assign s_tuser[1] = axi_s1_tuser_i;
  assign s_tkeep[0] = axi_s0_tkeep_i;
  assign s_tkeep[1] = axi_s1_tkeep_i;
  assign s_tlast    = {axi_s1_tlast_i, axi_s0_tlast_i};
  assign s_tvalid   = {axi_s1_tvalid_i, axi_s0_tvalid_i};
  assign grant      = {state_reg == GNT1, state_reg == GNT0};

  // The slice can take a beat when empty or when its current beat leaves this cycle.
  assign out_ready  = ~out_valid_reg | axi_m0_tready_i;

`ifndef AXI4_SWITCH_REQ_SUPRESS_EN
  logic unused_supress;
  assign unused_supress = ^s_req_supress;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
`ifdef AXI4_SWITCH_REQ_SUPRESS_EN
      assign req[gi] = s_tvalid[gi] & ~s_req_supress[gi];
`else
      assign req[gi] = s_tvalid[gi];
`endif
      assign s_tready[gi] = ~rst & grant[gi] & out_ready;
      assign s_take[gi]   = s_tready[gi] & s_tvalid[gi];
    end
  endgenerate

  assign take_any        = |s_take;
  assign sel_port        = grant[1];
  assign axi_s0_tready_o = s_tready[0];
  assign axi_s1_tready_o = s_tready[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // On a tie the port that was not served last wins.
          if (req[0] && (!req[1] || last_reg)) begin
            state_reg <= GNT0;
            last_reg  <= 1'b0;
          end else if (req[1]) begin
            state_reg <= GNT1;
            last_reg  <= 1'b1;
          end
        end
        GNT0: if (s_take[0] && s_tlast[0]) state_reg <= IDLE;
        GNT1: if (s_take[1] && s_tlast[1]) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (take_any)
        out_valid_reg <= 1'b1;
      else if (axi_m0_tready_i)
        out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (take_any) begin
      out_tdata_reg <= s_tdata[sel_port];
      out_tuser_reg <= s_tuser[sel_port];
      out_tkeep_reg <= s_tkeep[sel_port];
      out_tlast_reg <= s_tlast[sel_port];
    end
  end

  assign axi_m0_tdata_o  = out_tdata_reg;
  assign axi_m0_tuser_o  = out_tuser_reg;
  assign axi_m0_tkeep_o  = out_tkeep_reg;
  assign axi_m0_tlast_o  = out_tlast_reg;
  assign axi_m0_tvalid_o = out_valid_reg;

endmodule

// File: tb/tb_axi4_switch_custom.sv
// Self-checking bench for axi4_switch_custom: packet table plus hand-written corner sequences.
module tb_axi4_switch_custom;

  localparam int DW = 32;
  localparam int UW = 8;
  localparam int KW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct {
    int            port;
    int            beats;
    logic [DW-1:0] base;
    logic [UW-1:0] ubase;
    logic [KW-1:0] keep;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [1:0]    supress;
  logic [DW-1:0] s_tdata [2];
  logic [UW-1:0] s_tuser [2];
  logic [KW-1:0] s_tkeep [2];
  logic          s_tlast [2];
  logic          s_tvalid [2];
  logic [1:0]    s_tready;
  logic [DW-1:0] m_tdata;
  logic [UW-1:0] m_tuser;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_ready;

  int    tests = 0;
  int    fails = 0;
  beat_t sb[$];
  vec_t  vecs[6];

  axi4_switch_custom #(.TDATA_L(DW), .TUSER_L(UW), .TKEEP_L(KW)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_req_supress   (supress),
    .axi_s0_tdata_i  (s_tdata[0]),
    .axi_s0_tuser_i  (s_tuser[0]),
    .axi_s0_tkeep_i  (s_tkeep[0]),
    .axi_s0_tlast_i  (s_tlast[0]),
    .axi_s0_tvalid_i (s_tvalid[0]),
    .axi_s0_tready_o (s_tready[0]),
    .axi_s1_tdata_i  (s_tdata[1]),
    .axi_s1_tuser_i  (s_tuser[1]),
    .axi_s1_tkeep_i  (s_tkeep[1]),
    .axi_s1_tlast_i  (s_tlast[1]),
    .axi_s1_tvalid_i (s_tvalid[1]),
    .axi_s1_tready_o (s_tready[1]),
    .axi_m0_tdata_o  (m_tdata),
    .axi_m0_tuser_o  (m_tuser),
    .axi_m0_tkeep_o  (m_tkeep),
    .axi_m0_tlast_o  (m_tlast),
    .axi_m0_tvalid_o (m_tvalid),
    .axi_m0_tready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every master handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL m0_extra_beat: got d=%h required no beat", m_tdata);
      end else begin
        beat_t exp_b;
        beat_t got_b;
        exp_b = sb.pop_front();
        got_b.d = m_tdata;
        got_b.u = m_tuser;
        got_b.k = m_tkeep;
        got_b.l = m_tlast;
        check("m0_beat", 64'(got_b), 64'(exp_b));
        $display("[TB] m0 beat d=%h u=%h k=%h l=%0b", m_tdata, m_tuser, m_tkeep, m_tlast);
      end
    end
  end

  task automatic push_pkt(input int n, input logic [DW-1:0] base, input logic [UW-1:0] ub,
                          input logic [KW-1:0] k);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = base + DW'(i);
      b.u = ub + UW'(i);
      b.k = k;
      b.l = (i == n - 1);
      sb.push_back(b);
    end
  endtask

  task automatic wait_ready(input int p, output bit ok);
    int c = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (s_tready[p]) begin
        ok = 1'b1;
        return;
      end
      c++;
      if (c > 300) begin
        tests++;
        fails++;
        $display("FAIL s%0d_tready_timeout: got 0 required 1 within 300 cycles", p);
        return;
      end
    end
  endtask

  // Called at posedge+1; each beat is held until it is accepted.
  task automatic send_pkt(input int p, input int n, input logic [DW-1:0] base,
                          input logic [UW-1:0] ub, input logic [KW-1:0] k);
    bit ok;
    for (int i = 0; i < n; i++) begin
      s_tdata[p]  = base + DW'(i);
      s_tuser[p]  = ub + UW'(i);
      s_tkeep[p]  = k;
      s_tlast[p]  = (i == n - 1);
      s_tvalid[p] = 1'b1;
      wait_ready(p, ok);
      if (!ok) begin
        s_tvalid[p] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    s_tvalid[p] = 1'b0;
    s_tlast[p]  = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid[0] = 1'b0;
    s_tvalid[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m0_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_m0_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            ok;
    int            c;
    logic [1:0]    exp_first;
    vec_t          v;

    vecs[0] = '{port: 0, beats: 1, base: 32'hA0A0_0000, ubase: 8'h11, keep: 4'hF};
    vecs[1] = '{port: 1, beats: 1, base: 32'hB0B0_0000, ubase: 8'h22, keep: 4'h1};
    vecs[2] = '{port: 0, beats: 4, base: 32'hC000_0000, ubase: 8'h33, keep: 4'h3};
    vecs[3] = '{port: 1, beats: 2, base: 32'hFFFF_FFFE, ubase: 8'hFE, keep: 4'hF};
    vecs[4] = '{port: 0, beats: 3, base: 32'h0000_0000, ubase: 8'h00, keep: 4'h0};
    vecs[5] = '{port: 1, beats: 5, base: 32'h1234_5678, ubase: 8'h80, keep: 4'h8};

    rst      = 1'b1;
    supress  = 2'b00;
    m_ready  = 1'b1;
    for (int p = 0; p < 2; p++) begin
      s_tdata[p]  = '0;
      s_tuser[p]  = '0;
      s_tkeep[p]  = '0;
      s_tlast[p]  = 1'b0;
      s_tvalid[p] = 1'b0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single-beat packet: one-cycle latency after acceptance, seen exactly once.
    push_pkt(1, 32'hA0A0_0000, 8'h5C, 4'hF);
    fork
      send_pkt(0, 1, 32'hA0A0_0000, 8'h5C, 4'hF);
      begin
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!(s_tready[0] && s_tvalid[0]) && c < 50);
        check("single_accept_seen", 64'(s_tready[0]), 64'd1);
        @(negedge clk);
        check("single_m0_tvalid", 64'(m_tvalid), 64'd1);
        check("single_m0_tdata", 64'(m_tdata), 64'hA0A0_0000);
        check("single_m0_tlast", 64'(m_tlast), 64'd1);
        @(negedge clk);
        check("single_once", 64'(m_tvalid), 64'd0);
      end
    join
    drain();

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      push_pkt(v.beats, v.base, v.ubase, v.keep);
      send_pkt(v.port, v.beats, v.base, v.ubase, v.keep);
      drain();
    end

    // No interleaving: s1 packet starts first, s0 beat must follow it.
    push_pkt(3, 32'hB0B0_0001, 8'h40, 4'hF);
    push_pkt(1, 32'hA0A0_0004, 8'h50, 4'hF);
    fork
      send_pkt(1, 3, 32'hB0B0_0001, 8'h40, 4'hF);
      begin
        @(posedge clk);
        #1;
        send_pkt(0, 1, 32'hA0A0_0004, 8'h50, 4'hF);
      end
    join
    drain();

    // Tie fairness after reset: grants alternate 0,1,0,1.
    do_reset();
    push_pkt(2, 32'h0A00_0000, 8'h01, 4'hF);
    push_pkt(2, 32'h0B00_0000, 8'h02, 4'hF);
    push_pkt(2, 32'h0A00_0010, 8'h03, 4'hF);
    push_pkt(2, 32'h0B00_0010, 8'h04, 4'hF);
    fork
      begin
        send_pkt(0, 2, 32'h0A00_0000, 8'h01, 4'hF);
        send_pkt(0, 2, 32'h0A00_0010, 8'h03, 4'hF);
      end
      begin
        send_pkt(1, 2, 32'h0B00_0000, 8'h02, 4'hF);
        send_pkt(1, 2, 32'h0B00_0010, 8'h04, 4'hF);
      end
    join
    drain();

    // Back-pressure: master stalls 5 cycles mid-packet.
    push_pkt(4, 32'hD000_0000, 8'h60, 4'h7);
    fork
      send_pkt(0, 4, 32'hD000_0000, 8'h60, 4'h7);
      begin
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!m_tvalid && c < 50);
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("bp_m0_tvalid", 64'(m_tvalid), 64'd1);
          check("bp_m0_tdata_held", 64'(m_tdata), 64'(sb[0].d));
          check("bp_s0_tready", 64'(s_tready[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Suppression of port 0 while both ports request from IDLE.
    do_reset();
    supress = 2'b01;
`ifdef AXI4_SWITCH_REQ_SUPRESS_EN
    exp_first = 2'b10;
    push_pkt(1, 32'hF000_0001, 8'h71, 4'hF);
    push_pkt(1, 32'hE000_0001, 8'h70, 4'hF);
`else
    exp_first = 2'b01;
    push_pkt(1, 32'hE000_0001, 8'h70, 4'hF);
    push_pkt(1, 32'hF000_0001, 8'h71, 4'hF);
`endif
    fork
      send_pkt(0, 1, 32'hE000_0001, 8'h70, 4'hF);
      send_pkt(1, 1, 32'hF000_0001, 8'h71, 4'hF);
      begin
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (s_tready == 2'b00 && c < 50);
        check("supress_first_grant", 64'(s_tready), 64'(exp_first));
        @(posedge clk);
        #1;
        supress = 2'b00;
      end
    join
    drain();

    // Reset after the first of two beats: partial packet dropped, next packet intact.
    m_ready = 1'b0;
    s_tdata[0]  = 32'h5A5A_0001;
    s_tuser[0]  = 8'h90;
    s_tkeep[0]  = 4'hF;
    s_tlast[0]  = 1'b0;
    s_tvalid[0] = 1'b1;
    wait_ready(0, ok);
    @(posedge clk);
    #1;
    s_tdata[0] = 32'h5A5A_0002;
    s_tlast[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    s_tvalid[0] = 1'b0;
    s_tlast[0]  = 1'b0;
    @(negedge clk);
    check("midrst_m0_tvalid", 64'(m_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    s_tvalid[1] = 1'b1;
    s_tdata[1]  = 32'h5A5A_0010;
    s_tuser[1]  = 8'hA0;
    s_tkeep[1]  = 4'hF;
    @(negedge clk);
    check("midrst_release_m0_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_idle_tready", 64'(s_tready), 64'd0);
    s_tvalid[1] = 1'b0;
    @(posedge clk);
    #1;
    push_pkt(2, 32'h5A5A_0010, 8'hA0, 4'hF);
    send_pkt(1, 2, 32'h5A5A_0010, 8'hA0, 4'hF);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
